gb_bus_tx: RTL and testbench
============================

Name: gb_bus_tx

Overview:
- PU-side transmitter for the shared global bus between processing units (PUs).
- Queues outgoing words from the PU datapath, each tagged with a destination PU index.
- Presents the queue head on the PU's bus output slot and holds it until the top-level fixed-priority arbiter grants the slot. Lower PU index wins.
- Pops the word on grant and reports stall/starvation status for debug.

Parameters:
- puId, 0, index of the owning PU. Status only.
- logNumPu, 3, log2 of the number of PUs. Destination field width.
- dataLen, 16, bus data width.
- logFifoDepth, 2, log2 of queue depth (depth 4).
- stallCntLen, 8, width of the consecutive-stall counter.
- starveThresh, 64, stall count at which starve asserts.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous queue clear
- wr_v  input  1  push request from PU datapath
- wr_data  input  dataLen  word to send
- wr_dest  input  logNumPu  destination PU index
- wr_ready  output  1  queue can accept a push
- gb_bus_data_out  output  dataLen  head word to bus
- gb_bus_data_out_v  output  logNumPu+1  bit 0 = valid; bits [logNumPu:1] = destination PU
- gb_bus_contention  input  1  grant from arbiter; combinational in the same cycle as valid
- fifo_count  output  logFifoDepth+1  occupancy
- stall_cnt  output  stallCntLen  consecutive cycles valid without grant
- starve  output  1  stall_cnt >= starveThresh

Behaviour:
- Reset (reset=0, async) clears:
  - pointers and count; fifo_count=0
  - gb_bus_data_out_v=0, gb_bus_data_out=0
  - stall_cnt=0, starve=0
  - wr_ready=1 after reset is released.
- Storage and outputs:
  - Circular register queue with rd_ptr, wr_ptr and count.
  - gb_bus_data_out and gb_bus_data_out_v are driven directly from the head entry registers. No combinational path from wr_* to the bus outputs.
  - gb_bus_data_out_v[0] = (count != 0).
  - Upper bits of gb_bus_data_out_v = head dest. They are 0 when the queue is empty.
  - gb_bus_data_out = 0 when the queue is empty.
- push = wr_v && wr_ready, where wr_ready = (count != depth).
  - wr_ready has no dependence on grant, which keeps the arbiter path out of the PU datapath.
  - wr_v while full: the word is ignored and there is no state change. This is legal backpressure.
- pop = gb_bus_data_out_v[0] && gb_bus_contention, sampled at the clock edge.
  - A popped word is considered transferred in that cycle.
  - gb_bus_contention while empty is ignored.
- Latency: a word pushed into an empty queue at edge N is valid on the bus from cycle N+1. The earliest pop is at edge N+1.
- Simultaneous push and pop (non-full, non-empty): count unchanged, both pointers advance.
- Simultaneous push and pop with count=1: the new word becomes head after the edge. Valid stays 1 and the new data appears on the bus the next cycle.
- Pointer wrap: modulo depth. count is the sole full/empty authority.
- Status states, two-state FSM:
  - IDLE (count=0): stall_cnt held at 0.
  - REQ (count>0).
    - valid && !grant: stall_cnt increments, saturating at all-ones.
    - pop: stall_cnt clears to 0.
    - REQ→IDLE when a pop brings count to 0 with no push.
- starve is registered: 1 while stall_cnt >= starveThresh. Clears on the cycle after stall_cnt resets.
- flush:
  - Takes priority over push and pop in the same cycle.
  - Clears count, pointers and stall_cnt.
  - Any grant received in the flush cycle still counts as a transfer on the bus. The transmitter discards its copy; the receiver sees the word.
- Reset mid-transfer: the queue is lost and outputs drop immediately (async).
- Destination equal to puId is legal and passed through unchanged.

Decomposition:
- Shared package / include entries:
  - GB_V_BIT = 0
  - GB_DEST_LSB = 1
  - gbBusIndexLen = logNumPu+1 macro
  - default queue depth
- One natural sub-module: gb_tx_fifo. It is a synchronous register queue with count, flush and async active-low reset, and is reusable for the PU neighbour path.
- gb_bus_tx wraps it with the bus encoding and the stall/starve logic.

Test Plan:
- Reset with outputs forced high, then reset=0 → all outputs 0, wr_ready=1, fifo_count=0 immediately (async).
- Push data=0x1234, dest=5 with gb_bus_contention held 1 → next cycle out=0x1234, out_v=0b1011. One cycle later out_v=0, fifo_count=0.
- Push 4 words (0xA0..0xA3) with grant=0 → wr_ready=0, fifo_count=4. A 5th push (0xA4) is dropped. Then grant=1 for 4 cycles → bus shows 0xA0,A1,A2,A3 in order, then empty.
- Depth-1 queue with grant=1 and push 0xB1 in the same cycle → fifo_count stays 1, next cycle bus shows 0xB1 with no valid gap.
- One word queued, grant=0 for 70 cycles → stall_cnt=70, starve=1 from the cycle after stall_cnt reaches 64. Grant once → stall_cnt=0, starve=0 the following cycle.
- 3 words queued, flush plus push 0xC0 in the same cycle → fifo_count=0 and 0xC0 is not enqueued. wr_ready=1.

Source files
------------

// File: rtl/gb_bus_tx_pkg.sv
// Shared bus encoding, default queue sizing and status FSM states for the global-bus transmitter.
// Combinational declarations only; no latency and no flow control.
package gb_bus_tx_pkg;

    localparam int GB_V_BIT                  = 0;
    localparam int GB_DEST_LSB               = 1;
    localparam int GB_DEFAULT_LOG_FIFO_DEPTH = 2;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } gb_tx_state_e;

    // Width of the bus valid/destination field: one valid bit plus the PU index.
    function automatic int gb_bus_index_len(input int log_num_pu);
        return log_num_pu + 1;
    endfunction

endpackage

// File: rtl/gb_tx_fifo.sv
// Circular register queue with occupancy count and synchronous flush; the head is shown as soon as an entry is stored.
// Push-to-head latency is 1 cycle; push_rdy depends only on count, and a push while full is dropped with no state change.
module gb_tx_fifo #(
    parameter int WIDTH     = 16,
    parameter int LOG_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push_vld,
    input  logic [WIDTH-1:0]     push_dat,
    output logic                 push_rdy,
    input  logic                 pop_rdy,
    output logic                 head_vld,
    output logic [WIDTH-1:0]     head_dat,
    output logic [LOG_DEPTH:0]   count
);

    localparam int                 DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL  = (LOG_DEPTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic                 push;
    logic                 pop;

    assign push_rdy = (count != FULL);
    assign head_vld = (count != '0);
    assign push     = push_vld && push_rdy;
    assign pop      = pop_rdy && head_vld;
    // Stale storage is never exposed: an empty queue presents all zeros.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gb_bus_tx.sv
// PU-side global-bus transmitter: queues (dest, data) words and holds the head on the bus until the arbiter grants.
// Push-to-bus latency is 1 cycle; wr_ready depends only on occupancy, and grant pops the head in the same cycle.
module gb_bus_tx
    import gb_bus_tx_pkg::*;
#(
    parameter int puId         = 0,
    parameter int logNumPu     = 3,
    parameter int dataLen      = 16,
    parameter int logFifoDepth = GB_DEFAULT_LOG_FIFO_DEPTH,
    parameter int stallCntLen  = 8,
    parameter int starveThresh = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 wr_v,
    input  logic [dataLen-1:0]                   wr_data,
    input  logic [logNumPu-1:0]                  wr_dest,
    output logic                                 wr_ready,
    output logic [dataLen-1:0]                   gb_bus_data_out,
    output logic [gb_bus_index_len(logNumPu)-1:0] gb_bus_data_out_v,
    input  logic                                 gb_bus_contention,
    output logic [logFifoDepth:0]                fifo_count,
    output logic [stallCntLen-1:0]               stall_cnt,
    output logic                                 starve
);

    typedef struct packed {
        logic [logNumPu-1:0] dest;
        logic [dataLen-1:0]  data;
    } tx_entry_t;

    localparam int                      ENTRY_W   = $bits(tx_entry_t);
    localparam logic [stallCntLen-1:0]  STARVE_TH = stallCntLen'(starveThresh);
    localparam logic [logFifoDepth:0]   ONE_ENTRY = (logFifoDepth + 1)'(1);

    if ((puId < 0) || (puId >= (1 << logNumPu))) begin : g_bad_pu_id
        $error("gb_bus_tx: puId does not fit in the destination field");
    end

    tx_entry_t         wr_entry;
    tx_entry_t         head;
    logic [ENTRY_W-1:0] head_raw;
    logic              head_vld;
    logic              push;
    logic              pop;
    gb_tx_state_e      state;

    assign wr_entry = '{dest: wr_dest, data: wr_data};

    gb_tx_fifo #(
        .WIDTH     (ENTRY_W),
        .LOG_DEPTH (logFifoDepth)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push_vld (wr_v),
        .push_dat (wr_entry),
        .push_rdy (wr_ready),
        .pop_rdy  (gb_bus_contention),
        .head_vld (head_vld),
        .head_dat (head_raw),
        .count    (fifo_count)
    );

    assign head = head_raw;
    assign push = wr_v && wr_ready;
    assign pop  = head_vld && gb_bus_contention;

    // Bus slot comes straight off the queue head registers; the fifo zeroes it when empty.
    assign gb_bus_data_out                            = head.data;
    assign gb_bus_data_out_v[GB_V_BIT]                = head_vld;
    assign gb_bus_data_out_v[GB_DEST_LSB +: logNumPu] = head.dest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            stall_cnt <= '0;
            starve    <= 1'b0;
        end else begin
            starve <= (stall_cnt >= STARVE_TH);
            if (flush) begin
                state     <= ST_IDLE;
                stall_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        stall_cnt <= '0;
                        if (push) begin
                            state <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (pop) begin
                            stall_cnt <= '0;
                            if ((fifo_count == ONE_ENTRY) && !push) begin
                                state <= ST_IDLE;
                            end
                        end else if (head_vld && (stall_cnt != '1)) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        stall_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gb_bus_tx.sv
// Directed bench for gb_bus_tx: inputs driven and outputs sampled on the falling edge, expected values hand-computed.
module tb_gb_bus_tx;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        wr_v;
    logic [15:0] wr_data;
    logic [2:0]  wr_dest;
    logic        wr_ready;
    logic [15:0] gb_bus_data_out;
    logic [3:0]  gb_bus_data_out_v;
    logic        gb_bus_contention;
    logic [2:0]  fifo_count;
    logic [7:0]  stall_cnt;
    logic        starve;

    int n_checks = 0;
    int n_fail   = 0;

    gb_bus_tx #(
        .puId         (0),
        .logNumPu     (3),
        .dataLen      (16),
        .logFifoDepth (2),
        .stallCntLen  (8),
        .starveThresh (64)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .wr_v              (wr_v),
        .wr_data           (wr_data),
        .wr_dest           (wr_dest),
        .wr_ready          (wr_ready),
        .gb_bus_data_out   (gb_bus_data_out),
        .gb_bus_data_out_v (gb_bus_data_out_v),
        .gb_bus_contention (gb_bus_contention),
        .fifo_count        (fifo_count),
        .stall_cnt         (stall_cnt),
        .starve            (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        reset             = 1'b0;
        flush             = 1'b0;
        wr_v              = 1'b0;
        wr_data           = '0;
        wr_dest           = '0;
        gb_bus_contention = 1'b0;
        nxt();
        nxt();
        reset = 1'b1;
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(wr_ready), 1);
        chk("rst_v", 32'(gb_bus_data_out_v), 0);
        chk("rst_data", 32'(gb_bus_data_out), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_starve", 32'(starve), 0);

        // Async reset while a word is held on the bus
        wr_v = 1'b1; wr_data = 16'h5555; wr_dest = 3'd3;
        nxt();
        wr_v = 1'b0;
        chk("pre_rst_data", 32'(gb_bus_data_out), 32'h5555);
        chk("pre_rst_v", 32'(gb_bus_data_out_v), 32'h7);
        nxt();
        chk("pre_rst_stall", 32'(stall_cnt), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_data", 32'(gb_bus_data_out), 0);
        chk("async_rst_v", 32'(gb_bus_data_out_v), 0);
        chk("async_rst_count", 32'(fifo_count), 0);
        chk("async_rst_stall", 32'(stall_cnt), 0);
        chk("async_rst_ready", 32'(wr_ready), 1);
        nxt();
        reset = 1'b1;
        nxt();

        // Single word with grant held high
        wr_v = 1'b1; wr_data = 16'h1234; wr_dest = 3'd5; gb_bus_contention = 1'b1;
        nxt();
        wr_v = 1'b0;
        chk("single_data", 32'(gb_bus_data_out), 32'h1234);
        chk("single_v", 32'(gb_bus_data_out_v), 32'hB);
        chk("single_count", 32'(fifo_count), 1);
        nxt();
        chk("single_empty_v", 32'(gb_bus_data_out_v), 0);
        chk("single_empty_count", 32'(fifo_count), 0);
        chk("single_empty_data", 32'(gb_bus_data_out), 0);
        gb_bus_contention = 1'b0;

        // Fill to depth, drop a push while full, then drain in order
        for (int i = 0; i < 4; i++) begin
            wr_v = 1'b1; wr_data = 16'hA0 + 16'(i); wr_dest = 3'(i);
            nxt();
        end
        chk("full_count", 32'(fifo_count), 4);
        chk("full_ready", 32'(wr_ready), 0);
        wr_v = 1'b1; wr_data = 16'hA4; wr_dest = 3'd7;
        nxt();
        wr_v = 1'b0;
        chk("full_drop_count", 32'(fifo_count), 4);
        chk("full_stall", 32'(stall_cnt), 4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(gb_bus_data_out), 32'hA0 + 32'(i));
            chk("drain_v", 32'(gb_bus_data_out_v), 32'((i << 1) | 1));
            gb_bus_contention = 1'b1;
            nxt();
        end
        gb_bus_contention = 1'b0;
        chk("drain_empty_v", 32'(gb_bus_data_out_v), 0);
        chk("drain_empty_count", 32'(fifo_count), 0);
        chk("drain_ready", 32'(wr_ready), 1);

        // Push and pop together with a single entry queued
        wr_v = 1'b1; wr_data = 16'hB0; wr_dest = 3'd2;
        nxt();
        chk("d1_pre_data", 32'(gb_bus_data_out), 32'hB0);
        chk("d1_pre_count", 32'(fifo_count), 1);
        wr_v = 1'b1; wr_data = 16'hB1; wr_dest = 3'd6; gb_bus_contention = 1'b1;
        nxt();
        wr_v = 1'b0; gb_bus_contention = 1'b0;
        chk("d1_count", 32'(fifo_count), 1);
        chk("d1_data", 32'(gb_bus_data_out), 32'hB1);
        chk("d1_v", 32'(gb_bus_data_out_v), 32'hD);
        chk("d1_stall", 32'(stall_cnt), 0);
        gb_bus_contention = 1'b1;
        nxt();
        gb_bus_contention = 1'b0;
        chk("d1_empty_count", 32'(fifo_count), 0);

        // Stall counting and starvation
        wr_v = 1'b1; wr_data = 16'hD0; wr_dest = 3'd1;
        nxt();
        wr_v = 1'b0;
        repeat (63) nxt();
        chk("stall63", 32'(stall_cnt), 63);
        chk("starve_at63", 32'(starve), 0);
        nxt();
        chk("stall64", 32'(stall_cnt), 64);
        chk("starve_at64", 32'(starve), 0);
        nxt();
        chk("starve_at65", 32'(starve), 1);
        repeat (5) nxt();
        chk("stall70", 32'(stall_cnt), 70);
        chk("starve_at70", 32'(starve), 1);
        gb_bus_contention = 1'b1;
        nxt();
        gb_bus_contention = 1'b0;
        chk("stall_after_grant", 32'(stall_cnt), 0);
        chk("starve_lag", 32'(starve), 1);
        chk("stall_grant_count", 32'(fifo_count), 0);
        nxt();
        chk("starve_clear", 32'(starve), 0);

        // Flush wins over a push in the same cycle
        for (int i = 0; i < 3; i++) begin
            wr_v = 1'b1; wr_data = 16'hE0 + 16'(i); wr_dest = 3'd4;
            nxt();
        end
        chk("pre_flush_count", 32'(fifo_count), 3);
        chk("pre_flush_stall", 32'(stall_cnt), 2);
        flush = 1'b1; wr_v = 1'b1; wr_data = 16'hC0; wr_dest = 3'd1;
        nxt();
        flush = 1'b0; wr_v = 1'b0;
        chk("flush_count", 32'(fifo_count), 0);
        chk("flush_v", 32'(gb_bus_data_out_v), 0);
        chk("flush_ready", 32'(wr_ready), 1);
        chk("flush_stall", 32'(stall_cnt), 0);
        nxt();
        chk("flush_no_c0", 32'(fifo_count), 0);
        wr_v = 1'b1; wr_data = 16'hF0; wr_dest = 3'd0;
        nxt();
        wr_v = 1'b0;
        chk("post_flush_data", 32'(gb_bus_data_out), 32'hF0);
        chk("post_flush_v", 32'(gb_bus_data_out_v), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
